// File: rtl/video_timing_pkg.sv
// Shared constants, types and helpers for the raster timing generator.
// Holds the Tank Battalion default mode and an alternate 640x480 mode.
package video_timing_pkg;

  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int TANKB_H_ACTIVE = 256;
  localparam int TANKB_H_FP     = 16;
  localparam int TANKB_H_SYNC   = 32;
  localparam int TANKB_H_BP     = 80;
  localparam int TANKB_V_ACTIVE = 224;
  localparam int TANKB_V_FP     = 16;
  localparam int TANKB_V_SYNC   = 8;
  localparam int TANKB_V_BP     = 16;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } irq_state_t;

endpackage

// File: rtl/video_timing_gen_pix_clk_div.sv
// Pixel-enable divider: registered pix_ce, one clk wide, every CLK_DIV clks.
module pix_clk_div
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_ce
);

  localparam int DW = clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      pix_ce  <= (div_cnt == DIV_MAX);
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, sync/blank, tile strobes, vblank IRQ.
// Define VIDEO_IRQ_EN to build the vblank interrupt latch; otherwise irq_n is tied high.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_ACTIVE    = TANKB_H_ACTIVE,
  parameter int   H_FP        = TANKB_H_FP,
  parameter int   H_SYNC      = TANKB_H_SYNC,
  parameter int   H_BP        = TANKB_H_BP,
  parameter int   V_ACTIVE    = TANKB_V_ACTIVE,
  parameter int   V_FP        = TANKB_V_FP,
  parameter int   V_SYNC      = TANKB_V_SYNC,
  parameter int   V_BP        = TANKB_V_BP,
  parameter int   TILE_SHIFT  = 3,
  parameter int   FETCH_PHASE = 2,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  localparam int  H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW          = clog2(H_TOTAL),
  localparam int  VW          = clog2(V_TOTAL),
  localparam int  CW          = HW - TILE_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_ce,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          tile_fetch,
  output logic          tile_load,
  output logic [CW-1:0] tile_col,
  output logic          line_start,
  output logic          frame_start,
  input  logic          irq_ack_n,
  output logic          irq_n
);

  localparam logic [HW-1:0]         H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]         H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]         HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]         HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]         V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]         V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]         VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]         VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0]         COL_LAST = CW'((H_TOTAL >> TILE_SHIFT) - 1);
  localparam logic [TILE_SHIFT-1:0] FETCH_AT = TILE_SHIFT'(FETCH_PHASE);

  logic          run;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;

  pix_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_ce (pix_ce)
  );

  // The first pixel enable after reset presents (0,0) instead of advancing past it.
  always_comb begin
    h_nxt = hcnt;
    v_nxt = vcnt;
    if (pix_ce && run) begin
      if (hcnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        h_nxt = hcnt + 1'b1;
      end
    end
  end

  // Decodes are taken from next-state counts so they line up with hcnt/vcnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b0;
      tile_fetch  <= 1'b0;
      tile_load   <= 1'b0;
      tile_col    <= CW'(1);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      run         <= 1'b1;
      hcnt        <= h_nxt;
      vcnt        <= v_nxt;
      hsync       <= (h_nxt >= HS_START && h_nxt < HS_END) ? HS_POL : ~HS_POL;
      vsync       <= (v_nxt >= VS_START && v_nxt < VS_END) ? VS_POL : ~VS_POL;
      hblank      <= (h_nxt >= H_ACT);
      vblank      <= (v_nxt >= V_ACT);
      de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      tile_fetch  <= (h_nxt[TILE_SHIFT-1:0] == FETCH_AT);
      tile_load   <= &h_nxt[TILE_SHIFT-1:0];
      tile_col    <= (h_nxt[HW-1:TILE_SHIFT] == COL_LAST) ? '0
                                                          : h_nxt[HW-1:TILE_SHIFT] + 1'b1;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VIDEO_IRQ_EN
  irq_state_t irq_state;
  irq_state_t irq_state_nxt;
  logic       irq_set;

  assign irq_set = pix_ce && (h_nxt == '0) && (v_nxt == V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_state <= IDLE;
    else        irq_state <= irq_state_nxt;
  end

  // A set on the same edge as an acknowledge keeps the interrupt pending.
  always_comb begin
    irq_state_nxt = irq_state;
    case (irq_state)
      IDLE:    if (irq_set) irq_state_nxt = PEND;
      PEND:    if (!irq_set && !irq_ack_n) irq_state_nxt = IDLE;
      default: irq_state_nxt = IDLE;
    endcase
  end

  assign irq_n = (irq_state != PEND);
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack_n;
  assign irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: Tank Battalion defaults, VGA640 at CLK_DIV=1,
// and a tiny mode that wraps whole frames quickly for the vblank interrupt.
module tb_video_timing_gen;
  import video_timing_pkg::*;

`ifdef VIDEO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef struct packed {
    logic        pix_ce;
    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic        hsync, vsync, hblank, vblank, de, tf, tl;
    logic [15:0] col;
    logic        ls, fs, irq_n;
  } out_t;

  typedef struct {
    int div, ha, hfp, hs, hbp, va, vfp, vs, vbp, ts, fp;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int   edges;
    out_t exp;
  } vec_t;

  logic clk, rst_n, irq_ack_n;

  logic pce_a, hs_a, vs_a, hb_a, vb_a, de_a, tf_a, tl_a, ls_a, fs_a, irq_a;
  logic [8:0] hcnt_a, vcnt_a;
  logic [5:0] col_a;
  logic pce_b, hs_b, vs_b, hb_b, vb_b, de_b, tf_b, tl_b, ls_b, fs_b, irq_b;
  logic [9:0] hcnt_b, vcnt_b;
  logic [6:0] col_b;
  logic pce_c, hs_c, vs_c, hb_c, vb_c, de_c, tf_c, tl_c, ls_c, fs_c, irq_c;
  logic [4:0] hcnt_c;
  logic [3:0] vcnt_c;
  logic [2:0] col_c;

  video_timing_gen u_a (
    .clk(clk), .rst_n(rst_n), .pix_ce(pce_a), .hcnt(hcnt_a), .vcnt(vcnt_a),
    .hsync(hs_a), .vsync(vs_a), .hblank(hb_a), .vblank(vb_a), .de(de_a),
    .tile_fetch(tf_a), .tile_load(tl_a), .tile_col(col_a), .line_start(ls_a),
    .frame_start(fs_a), .irq_ack_n(irq_ack_n), .irq_n(irq_a));

  video_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(VGA640_H_ACTIVE), .H_FP(VGA640_H_FP), .H_SYNC(VGA640_H_SYNC),
    .H_BP(VGA640_H_BP), .V_ACTIVE(VGA640_V_ACTIVE), .V_FP(VGA640_V_FP),
    .V_SYNC(VGA640_V_SYNC), .V_BP(VGA640_V_BP)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pix_ce(pce_b), .hcnt(hcnt_b), .vcnt(vcnt_b),
    .hsync(hs_b), .vsync(vs_b), .hblank(hb_b), .vblank(vb_b), .de(de_b),
    .tile_fetch(tf_b), .tile_load(tl_b), .tile_col(col_b), .line_start(ls_b),
    .frame_start(fs_b), .irq_ack_n(irq_ack_n), .irq_n(irq_b));

  video_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .TILE_SHIFT(2), .FETCH_PHASE(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .pix_ce(pce_c), .hcnt(hcnt_c), .vcnt(vcnt_c),
    .hsync(hs_c), .vsync(vs_c), .hblank(hb_c), .vblank(vb_c), .de(de_c),
    .tile_fetch(tf_c), .tile_load(tl_c), .tile_col(col_c), .line_start(ls_c),
    .frame_start(fs_c), .irq_ack_n(irq_ack_n), .irq_n(irq_c));

  out_t act [3];
  assign act[0] = {pce_a, 16'(hcnt_a), 16'(vcnt_a), hs_a, vs_a, hb_a, vb_a, de_a,
                   tf_a, tl_a, 16'(col_a), ls_a, fs_a, irq_a};
  assign act[1] = {pce_b, 16'(hcnt_b), 16'(vcnt_b), hs_b, vs_b, hb_b, vb_b, de_b,
                   tf_b, tl_b, 16'(col_b), ls_b, fs_b, irq_b};
  assign act[2] = {pce_c, 16'(hcnt_c), 16'(vcnt_c), hs_c, vs_c, hb_c, vb_c, de_c,
                   tf_c, tl_c, 16'(col_c), ls_c, fs_c, irq_c};

  cfg_t cfg [3];
  int   n [3];
  bit   pend [3];
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  vec_t tbl [17];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: n clk edges since reset release determine everything.
  // pix_ce is high after edges div, 2*div, ...; pixel P is shown after edge (P+1)*div+1.
  function automatic out_t model(cfg_t c, int edges, bit pnd);
    out_t o;
    int ht, vt, p, h, v, sub;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    o = '0;
    o.pix_ce = (edges >= c.div) && (edges % c.div == 0);
    o.hsync  = !c.hpol;
    o.vsync  = !c.vpol;
    o.col    = 16'd1;
    o.irq_n  = IRQ_EN ? !pnd : 1'b1;
    if (edges > c.div) begin
      p   = (edges - 1) / c.div - 1;
      h   = p % ht;
      v   = (p / ht) % vt;
      sub = h % (1 << c.ts);
      o.hcnt   = 16'(h);
      o.vcnt   = 16'(v);
      o.hsync  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hpol : !c.hpol;
      o.vsync  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vpol : !c.vpol;
      o.hblank = (h >= c.ha);
      o.vblank = (v >= c.va);
      o.de     = (h < c.ha) && (v < c.va);
      o.tf     = (sub == c.fp);
      o.tl     = (sub == (1 << c.ts) - 1);
      o.col    = 16'(((h >> c.ts) + 1) % (ht >> c.ts));
      o.ls     = (h == 0);
      o.fs     = (h == 0) && (v == 0);
    end
    return o;
  endfunction

  function automatic bit is_set(cfg_t c, int edges);
    out_t o;
    if (edges <= c.div || ((edges - 1) % c.div) != 0) return 1'b0;
    o = model(c, edges, 1'b0);
    return (o.hcnt == 16'(0)) && (o.vcnt == 16'(c.va));
  endfunction

  function automatic out_t mk(bit pc, int h, int v, bit hs, bit hb, bit d, bit tf, bit tl,
                              int col, bit ls, bit fs);
    out_t o;
    o = '0;
    o.pix_ce = pc; o.hcnt = 16'(h); o.vcnt = 16'(v); o.hsync = hs; o.vsync = 1'b1;
    o.hblank = hb; o.vblank = 1'b0; o.de = d; o.tf = tf; o.tl = tl; o.col = 16'(col);
    o.ls = ls; o.fs = fs; o.irq_n = 1'b1;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        n[i]    = 0;
        pend[i] = 1'b0;
      end else begin
        n[i]++;
        if (is_set(cfg[i], n[i])) pend[i] = 1'b1;
        else if (!irq_ack_n)      pend[i] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      out_t e;
      e = model(cfg[i], n[i], pend[i]);
      vec_cnt++;
      if (act[i] !== e) begin
        miss_cnt++;
        $display("FAIL %s dut%0d edge=%0d got %h exp %h", tag, i, n[i], act[i], e);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic run_to(input int idx, input int target, input string tag);
    while (n[idx] < target) begin
      step();
      check_all(tag);
    end
  endtask

  initial begin
    int s;
    cfg[0] = '{div:4, ha:256, hfp:16, hs:32, hbp:80, va:224, vfp:16, vs:8, vbp:16,
               ts:3, fp:2, hpol:1'b0, vpol:1'b0};
    cfg[1] = '{div:1, ha:VGA640_H_ACTIVE, hfp:VGA640_H_FP, hs:VGA640_H_SYNC,
               hbp:VGA640_H_BP, va:VGA640_V_ACTIVE, vfp:VGA640_V_FP,
               vs:VGA640_V_SYNC, vbp:VGA640_V_BP, ts:3, fp:2, hpol:1'b0, vpol:1'b0};
    cfg[2] = '{div:2, ha:16, hfp:2, hs:4, hbp:2, va:6, vfp:2, vs:2, vbp:2,
               ts:2, fp:1, hpol:1'b1, vpol:1'b1};

    // Default-mode expectations: pixel P is visible from edge 4P+5.
    tbl[0]  = '{edges:3,    exp:mk(0,   0, 0, 1, 0, 0, 0, 0,  1, 0, 0)};
    tbl[1]  = '{edges:4,    exp:mk(1,   0, 0, 1, 0, 0, 0, 0,  1, 0, 0)};
    tbl[2]  = '{edges:5,    exp:mk(0,   0, 0, 1, 0, 1, 0, 0,  1, 1, 1)};
    tbl[3]  = '{edges:8,    exp:mk(1,   0, 0, 1, 0, 1, 0, 0,  1, 1, 1)};
    tbl[4]  = '{edges:13,   exp:mk(0,   2, 0, 1, 0, 1, 1, 0,  1, 0, 0)};
    tbl[5]  = '{edges:33,   exp:mk(0,   7, 0, 1, 0, 1, 0, 1,  1, 0, 0)};
    tbl[6]  = '{edges:37,   exp:mk(0,   8, 0, 1, 0, 1, 0, 0,  2, 0, 0)};
    tbl[7]  = '{edges:1025, exp:mk(0, 255, 0, 1, 0, 1, 0, 1, 32, 0, 0)};
    tbl[8]  = '{edges:1029, exp:mk(0, 256, 0, 1, 1, 0, 0, 0, 33, 0, 0)};
    tbl[9]  = '{edges:1089, exp:mk(0, 271, 0, 1, 1, 0, 0, 1, 34, 0, 0)};
    tbl[10] = '{edges:1093, exp:mk(0, 272, 0, 0, 1, 0, 0, 0, 35, 0, 0)};
    tbl[11] = '{edges:1217, exp:mk(0, 303, 0, 0, 1, 0, 0, 1, 38, 0, 0)};
    tbl[12] = '{edges:1221, exp:mk(0, 304, 0, 1, 1, 0, 0, 0, 39, 0, 0)};
    tbl[13] = '{edges:1517, exp:mk(0, 378, 0, 1, 1, 0, 1, 0,  0, 0, 0)};
    tbl[14] = '{edges:1537, exp:mk(0, 383, 0, 1, 1, 0, 0, 1,  0, 0, 0)};
    tbl[15] = '{edges:1541, exp:mk(0,   0, 1, 1, 0, 1, 0, 0,  1, 1, 0)};
    tbl[16] = '{edges:1549, exp:mk(0,   2, 1, 1, 0, 1, 1, 0,  1, 0, 0)};

    for (int i = 0; i < 3; i++) begin
      n[i]    = 0;
      pend[i] = 1'b0;
    end
    rst_n     = 1'b0;
    irq_ack_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("reset");
    end
    rst_n = 1'b1;

    for (int t = 0; t < 17; t++) begin
      run_to(0, tbl[t].edges, "run");
      vec_cnt++;
      if (act[0] !== tbl[t].exp) begin
        miss_cnt++;
        $display("FAIL table[%0d] edge=%0d got %h exp %h", t, n[0], act[0], tbl[t].exp);
      end
    end

    for (int k = 0; k < 3000; k++) begin
      irq_ack_n = ($urandom_range(0, 5) != 0);
      step();
      check_all("random");
    end
    irq_ack_n = 1'b1;

    // Acknowledge held low across the set edge: set must win.
    s = -1;
    for (int m = n[2] + 1; m < n[2] + 700; m++)
      if (s < 0 && is_set(cfg[2], m)) s = m;
    if (s < 0) begin
      miss_cnt++;
      $display("FAIL irq_set_search got none exp edge");
    end else begin
      run_to(2, s - 3, "pre_set");
      irq_ack_n = 1'b0;
      run_to(2, s, "ack_held");
      check_bit("irq_set_wins", irq_c, IRQ_EN ? 1'b0 : 1'b1);
      run_to(2, s + 3, "ack_held");
      check_bit("irq_cleared_by_held_ack", irq_c, 1'b1);
      irq_ack_n = 1'b1;

      // Next frame: ack at pixel (5, V_ACTIVE) releases irq_n one clk later.
      s = s + 288 * 2;
      run_to(2, s + 5 * 2, "pre_ack");
      check_bit("irq_pending_at_5", irq_c, IRQ_EN ? 1'b0 : 1'b1);
      irq_ack_n = 1'b0;
      step();
      check_all("ack_pulse");
      check_bit("irq_released", irq_c, 1'b1);
      irq_ack_n = 1'b1;
    end

    // Asynchronous reset mid-line.
    for (int k = 0; k < 900 && model(cfg[1], n[1], 1'b0).hcnt < 16'd100; k++) begin
      step();
      check_all("pre_rst");
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n[i]    = 0;
      pend[i] = 1'b0;
    end
    check_all("async_rst");
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("rst_hold");
    end
    rst_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      irq_ack_n = ($urandom_range(0, 3) != 0);
      step();
      check_all("post_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the arcade video path. It replaces the fixed 74161/7474 horizontal and vertical counter chain with a configurable pixel-enable divider, H/V counters, sync, blanking, tile-fetch strobes and a vblank interrupt latch with CPU acknowledge. It sits between the system clock and the tile renderer and CPU glue: the renderer consumes counters and strobes, and the CPU consumes `irq_n`.

## Interface
Parameters:
- `CLK_DIV`, 4: clk cycles per pixel, 1..16.
- `H_ACTIVE`, 256: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 32: horizontal sync width, in pixels.
- `H_BP`, 80: horizontal back porch, in pixels. Line total is 384.
- `V_ACTIVE`, 224: visible lines per frame.
- `V_FP`, 16: vertical front porch, in lines.
- `V_SYNC`, 8: vertical sync width, in lines.
- `V_BP`, 16: vertical back porch, in lines. Frame total is 264.
- `TILE_SHIFT`, 3: log2 of the tile width in pixels.
- `FETCH_PHASE`, 2: tile sub-pixel index at which `tile_fetch` asserts. Must be less than 2^TILE_SHIFT − 1.
- `HS_POL`, 0: active level of `hsync`.
- `VS_POL`, 0: active level of `vsync`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pix_ce` out 1: one-clk pixel enable.
- `hcnt` out HW: horizontal count. HW = clog2(H_total).
- `vcnt` out VW: vertical count. VW = clog2(V_total).
- `hsync` out 1: horizontal sync, active level set by `HS_POL`.
- `vsync` out 1: vertical sync, active level set by `VS_POL`.
- `hblank` out 1: high when `hcnt` ≥ H_ACTIVE.
- `vblank` out 1: high when `vcnt` ≥ V_ACTIVE.
- `de` out 1: display enable, equal to !hblank && !vblank.
- `tile_fetch` out 1: tile-fetch strobe.
- `tile_load` out 1: shift-register load strobe.
- `tile_col` out HW−TILE_SHIFT: column index of the next tile.
- `line_start` out 1: high for the pixel at hcnt == 0.
- `frame_start` out 1: high for the pixel at hcnt == 0 and vcnt == 0.
- `irq_ack_n` in 1: active-low interrupt acknowledge, synchronous to `clk`.
- `irq_n` out 1: active-low vblank interrupt.

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV−1. `pix_ce` is registered and high for exactly one clk when `div_cnt` == CLK_DIV−1. With CLK_DIV = 1, `pix_ce` is 1 on every clk after reset.
- On a clk edge with `pix_ce` = 1, `hcnt` increments. It wraps at H_total−1 to 0, and on that wrap `vcnt` increments, wrapping at V_total−1 to 0.
- Decoded outputs are registered from next-state counts, so they are always aligned with `hcnt`/`vcnt` and have zero latency relative to them. Decoded outputs: sync, blank, `de`, strobes, `tile_col`, `line_start`, `frame_start`.
- `hsync` is active for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
- `vsync` is active for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, and changes only on `hcnt` wrap.
- `tile_fetch` is high when hcnt[TILE_SHIFT−1:0] == FETCH_PHASE.
- `tile_load` is high when hcnt[TILE_SHIFT−1:0] == 2^TILE_SHIFT−1.
- `tile_fetch` and `tile_load` also run during blanking, so the first visible tile is prefetched. Consumers qualify both with `pix_ce`.
- `tile_col` = ((hcnt >> TILE_SHIFT) + 1) mod (H_total >> TILE_SHIFT).
- IRQ latch states are IDLE (`irq_n` = 1) and PEND (`irq_n` = 0).
  - IDLE→PEND on the pixel edge where vcnt becomes V_ACTIVE and hcnt becomes 0.
  - PEND→IDLE on any clk edge where `irq_ack_n` = 0.
  - If set and acknowledge occur on the same edge, set wins and the latch stays in or enters PEND.
  - Acknowledge while in IDLE has no effect.
- Reset, asynchronous:
  - div_cnt = 0, hcnt = 0, vcnt = 0, `pix_ce` = 0.
  - Syncs at their inactive level; `hblank` = 0, `vblank` = 0.
  - `de` = 0, `tile_fetch` = 0, `tile_load` = 0, `tile_col` = 1.
  - `line_start` = 0, `frame_start` = 0, `irq_n` = 1.
  - Reset mid-frame aborts the frame immediately. No partial sync pulse is held.

## Timing
- The first `pix_ce` occurs CLK_DIV clk edges after `rst_n` deasserts.
- The first counted pixel (0,0) follows with `de` = 1, `line_start` = 1 and `frame_start` = 1.
- All outputs are registered. `pix_ce` has a period of exactly CLK_DIV clks.
- `irq_n` falls on the same edge at which `vblank` rises. It rises one clk after `irq_ack_n` is sampled low.
- `irq_ack_n` needs no synchroniser, because the CPU shares `clk`.

## Configuration
- `VIDEO_IRQ_EN` defined: the IRQ latch is built as described above.
- `VIDEO_IRQ_EN` undefined: the latch is removed, `irq_n` is tied to 1, and `irq_ack_n` is ignored.

## Structure
- Package `video_timing_pkg` holds:
  - the `clog2` function;
  - default Tank Battalion mode constants (`TANKB_H_*`, `TANKB_V_*`);
  - alternate `VGA640_H_*` / `VGA640_V_*` constants;
  - the `irq_state_t` enum (IDLE, PEND).
- One sub-module, `pix_clk_div`, contains the divider and `pix_ce` generation.

## Test plan
- Reset release with defaults: `pix_ce` first high at clk 4, then every 4 clks; counters at (0,0) with `de` = 1 and `frame_start` = 1.
- Run one full line: `hsync` low for hcnt 272..303; `hblank` rises at hcnt 256; `hcnt` wraps 383→0 and `vcnt` goes 0→1.
- Run one frame: `vsync` low for vcnt 240..247; `vblank` is high for vcnt 224..263; `frame_start` pulses once per 264×384 pixels.
- Tile strobes: `tile_fetch` high at hcnt 2, 10, …, 378; `tile_load` high at 7, 15, …, 383; at hcnt 383 `tile_col` = 0.
- IRQ: `irq_n` falls at (0,224). Ack at (5,224) raises it the next clk. Ack held low across (0,224) of the next frame still yields `irq_n` = 0 because set wins.
- CLK_DIV = 1 with VGA640 constants: `pix_ce` constant 1, line total 800, frame total 525. Asserting `rst_n` = 0 mid-line returns all outputs to their reset values asynchronously.
